// File: rtl/maze_dpram_clr_if.sv
// Bus bundle for maze_dpram_clr: clear-engine control plus two RAM ports.
//   clr_req/clr_val/busy : clear engine request, fill value, sweep-in-progress flag
//   ena/wea/addra/dina/douta : port A enable, write enable, address, write data, read data
//   enb/web/addrb/dinb/doutb : port B, same meaning as port A
//   coll : one-cycle pulse after both ports wrote the same address
// The master modport drives the requests and receives the results; the RAM uses the slave modport.
interface maze_dpram_clr_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic              clr_req;
    logic [DATA_W-1:0] clr_val;
    logic              busy;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              enb;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;
    logic              coll;

    modport master (
        output clr_req, clr_val, ena, wea, addra, dina, enb, web, addrb, dinb,
        input  busy, douta, doutb, coll
    );

    modport slave (
        input  clr_req, clr_val, ena, wea, addra, dina, enb, web, addrb, dinb,
        output busy, douta, doutb, coll
    );
endinterface

// File: rtl/maze_dpram_clr.sv
// maze_dpram_clr: true dual-port RAM for maze map/state storage with a
// per-port read-during-write mode, write-collision flag and a clear engine
// that sweeps every word to clr_val after reset or on clr_req.
// Ports:
//   clk : single clock for both ports and the clear engine
//   rst : asynchronous active-high reset (restarts the clear sweep)
//   bus : maze_dpram_clr_if.slave carrying the clear control and both RAM ports
module maze_dpram_clr #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 1 << ADDR_W,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    maze_dpram_clr_if.slave     bus
);
    // Highest valid word index, one bit wider than an address so the
    // clear pointer and the range checks share the same width.
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] douta_q, douta_d;
    logic [DATA_W-1:0] doutb_q, doutb_d;
    logic              coll_q, coll_d;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic busy;
    logic a_in, b_in;
    logic a_wr, b_wr_req, b_wr, same_addr;

    assign busy      = (state_q == CLEAR);
    assign a_in      = ({1'b0, bus.addra} <= LAST);
    assign b_in      = ({1'b0, bus.addrb} <= LAST);
    assign same_addr = (bus.addra == bus.addrb);
    assign a_wr      = !busy && bus.ena && bus.wea && a_in;
    assign b_wr_req  = !busy && bus.enb && bus.web && b_in;
    // On a collision port A wins; port B's write is dropped.
    assign b_wr      = b_wr_req && !(a_wr && same_addr);

    // Clear-engine FSM, next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-data and collision next state. While the sweep runs the outputs
    // hold, so a reader never sees a half-cleared memory mid-transaction.
    always_comb begin
        douta_d = douta_q;
        doutb_d = doutb_q;
        coll_d  = 1'b0;
        if (!busy) begin
            coll_d = a_wr && b_wr_req && same_addr;
            if (bus.ena) begin
                if (!a_in) begin
                    douta_d = '0;
                end else if (bus.wea && RDW_MODE == 1) begin
                    douta_d = bus.dina;
                end else begin
                    douta_d = mem[bus.addra];
                end
            end
            if (bus.enb) begin
                if (!b_in) begin
                    doutb_d = '0;
                end else if (bus.web && RDW_MODE == 1) begin
                    // Write-first returns the word actually stored.
                    doutb_d = b_wr ? bus.dinb : bus.dina;
                end else begin
                    doutb_d = mem[bus.addrb];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            douta_q <= '0;
            doutb_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            douta_q <= douta_d;
            doutb_q <= doutb_d;
            coll_q  <= coll_d;
        end
    end

    // Memory array: no reset, contents change only through writes/sweep.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr_q[ADDR_W-1:0]] <= bus.clr_val;
        end else begin
            if (a_wr) begin
                mem[bus.addra] <= bus.dina;
            end
            if (b_wr) begin
                mem[bus.addrb] <= bus.dinb;
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.douta = douta_q;
    assign bus.doutb = doutb_q;
    assign bus.coll  = coll_q;
endmodule

// File: tb/tb_maze_dpram_clr.sv
// Directed bench for maze_dpram_clr. Three instances share one stimulus:
//   u0: 512 words, read-first; u1: 512 words, write-first; u2: 300 words, read-first.
module tb_maze_dpram_clr;
    logic        clk;
    logic        rst;
    logic        clr_req;
    logic [15:0] clr_val;
    logic        ena, wea, enb, web;
    logic [8:0]  addra, addrb;
    logic [15:0] dina, dinb;

    int vecs = 0;
    int errs = 0;
    int cnt;

    maze_dpram_clr_if #(.DATA_W(16), .ADDR_W(9)) bus0 ();
    maze_dpram_clr_if #(.DATA_W(16), .ADDR_W(9)) bus1 ();
    maze_dpram_clr_if #(.DATA_W(16), .ADDR_W(9)) bus2 ();

    assign {bus0.clr_req, bus0.clr_val, bus0.ena, bus0.wea, bus0.addra, bus0.dina,
            bus0.enb, bus0.web, bus0.addrb, bus0.dinb} =
           {clr_req, clr_val, ena, wea, addra, dina, enb, web, addrb, dinb};
    assign {bus1.clr_req, bus1.clr_val, bus1.ena, bus1.wea, bus1.addra, bus1.dina,
            bus1.enb, bus1.web, bus1.addrb, bus1.dinb} =
           {clr_req, clr_val, ena, wea, addra, dina, enb, web, addrb, dinb};
    assign {bus2.clr_req, bus2.clr_val, bus2.ena, bus2.wea, bus2.addra, bus2.dina,
            bus2.enb, bus2.web, bus2.addrb, bus2.dinb} =
           {clr_req, clr_val, ena, wea, addra, dina, enb, web, addrb, dinb};

    maze_dpram_clr #(.DATA_W(16), .ADDR_W(9), .DEPTH(512), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    maze_dpram_clr #(.DATA_W(16), .ADDR_W(9), .DEPTH(512), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));
    maze_dpram_clr #(.DATA_W(16), .ADDR_W(9), .DEPTH(300), .RDW_MODE(0)) u2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp,
                       input bit quiet = 1'b0);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
        if (!quiet) $display("check %-14s got %h expected %h", tag, got, exp);
    endtask

    // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        ena = 0; wea = 0; enb = 0; web = 0;
    endtask

    task automatic wait_clear(input string tag);
        cnt = 0;
        while (bus0.busy === 1'b1 && cnt < 2000) begin
            step();
            cnt++;
        end
        chk(tag, 16'(cnt), 16'd512);
    endtask

    initial begin
        rst = 1; clr_req = 0; clr_val = 16'hFFFF;
        ena = 0; wea = 0; addra = 0; dina = 0;
        enb = 0; web = 0; addrb = 0; dinb = 0;

        // Reset state
        #12;
        chk("rst_busy", 16'(bus0.busy), 16'd1);
        chk("rst_douta", bus0.douta, 16'h0000);
        chk("rst_doutb", bus0.doutb, 16'h0000);
        chk("rst_coll", 16'(bus0.coll), 16'd0);

        // T1: sweep length after reset, then all-FFFF contents
        step();
        rst = 0;
        wait_clear("t1_busy_len");
        chk("t1_u2_idle", 16'(bus2.busy), 16'd0);
        ena = 1; addra = 9'd0; enb = 1; addrb = 9'd511;
        step();
        chk("t1_rd0", bus0.douta, 16'hFFFF);
        chk("t1_rd511", bus0.doutb, 16'hFFFF);
        addra = 9'd255;
        step();
        chk("t1_rd255", bus0.douta, 16'hFFFF);
        idle_ports();

        // T2: A writes, B reads the next cycle
        ena = 1; wea = 1; addra = 9'd5; dina = 16'h1234;
        step();
        idle_ports();
        enb = 1; addrb = 9'd5;
        step();
        chk("t2_b_read", bus0.doutb, 16'h1234);
        idle_ports();
        step();
        chk("t2_b_hold", bus0.doutb, 16'h1234);

        // T3: read-during-write, read-first vs write-first
        ena = 1; wea = 1; addra = 9'd7; dina = 16'h0001;
        step();
        dina = 16'hABCD;
        step();
        chk("t3_rdw_mode0", bus0.douta, 16'h0001);
        chk("t3_rdw_mode1", bus1.douta, 16'hABCD);
        wea = 0;
        step();
        chk("t3_reread", bus0.douta, 16'hABCD);
        idle_ports();

        // T4: write collision, A wins, coll pulses one cycle
        ena = 1; wea = 1; addra = 9'd9; dina = 16'hAAAA;
        enb = 1; web = 1; addrb = 9'd9; dinb = 16'h5555;
        step();
        chk("t4_coll_hi", 16'(bus0.coll), 16'd1);
        idle_ports();
        enb = 1; addrb = 9'd9;
        step();
        chk("t4_coll_lo", 16'(bus0.coll), 16'd0);
        chk("t4_a_wins", bus0.doutb, 16'hAAAA);
        // different addresses: no collision
        ena = 1; wea = 1; addra = 9'd10; dina = 16'h0A0A;
        enb = 1; web = 1; addrb = 9'd11; dinb = 16'h0B0B;
        step();
        idle_ports();
        step();
        chk("t4_no_coll", 16'(bus0.coll), 16'd0);

        // T6: out-of-range access on the 300-word instance
        ena = 1; wea = 1; addra = 9'd400; dina = 16'hBEEF;
        enb = 1; web = 1; addrb = 9'd400; dinb = 16'h1111;
        step();
        chk("t6_oor_wr_rd", bus2.douta, 16'h0000);
        idle_ports();
        step();
        chk("t6_oor_coll", 16'(bus2.coll), 16'd0);
        ena = 1; wea = 1; addra = 9'd299; dina = 16'h2222;
        step();
        wea = 0;
        step();
        chk("t6_rd299", bus2.douta, 16'h2222);
        addra = 9'd400;
        step();
        chk("t6_rd400", bus2.douta, 16'h0000);
        idle_ports();

        // T5: clear on request, writes ignored while busy, reset mid-sweep
        ena = 1; wea = 1; addra = 9'd20; dina = 16'h1357;
        enb = 1; web = 1; addrb = 9'd300; dinb = 16'h2468;
        step();
        wea = 0; web = 0;
        step();
        chk("t5_pre_a", bus0.douta, 16'h1357);
        chk("t5_pre_b", bus0.doutb, 16'h2468);
        idle_ports();
        clr_val = 16'h0000; clr_req = 1;
        step();
        clr_req = 0;
        chk("t5_busy", 16'(bus0.busy), 16'd1);
        ena = 1; wea = 1; addra = 9'd20; dina = 16'h7777;
        enb = 1; addrb = 9'd300;
        clr_req = 1;
        step();
        chk("t5_hold_a", bus0.douta, 16'h1357);
        chk("t5_hold_b", bus0.doutb, 16'h2468);
        clr_req = 0;
        for (int i = 0; i < 99; i++) step();
        chk("t5_still_busy", 16'(bus0.busy), 16'd1);
        rst = 1;
        #2;
        chk("t5_rst_douta", bus0.douta, 16'h0000);
        rst = 0;
        wait_clear("t5_busy_len");
        idle_ports();
        for (int i = 0; i < 256; i++) begin
            ena = 1; addra = 9'(i); enb = 1; addrb = 9'(i + 256);
            step();
            chk($sformatf("t5_a%0d", i), bus0.douta, 16'h0000, 1'b1);
            chk($sformatf("t5_b%0d", i + 256), bus0.doutb, 16'h0000, 1'b1);
        end
        idle_ports();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
